npu_host_driver: RTL
====================

# npu_host_driver

Host-side initiator for the NPU's single-port register/memory window (ena/wea/addra/dina/douta). It accepts a stream of simple commands (write, read, poll-until-match, wait), converts each into correctly timed port cycles, and returns read data. It sits between a test sequencer or soft-CPU command FIFO and the NPU top. This lets the full conv1 → conv2 → FC flow be scripted as a command list without cycle-accurate host code.

## Interface
Parameters:
- ADDR_W, 16, port address width
- DATA_W, 32, port data width
- POLL_MAX, 4096, maximum reads per POLL command before timeout (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both valid and ready are high
- cmd_op  in  2  0 WRITE, 1 READ, 2 POLL, 3 WAIT
- cmd_addr  in  ADDR_W  port address
- cmd_data  in  DATA_W  write data / poll expected value / WAIT count in bits [15:0]
- cmd_mask  in  DATA_W  poll compare mask
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure
- rsp_data  out  DATA_W  captured douta
- rsp_timeout  out  1  qualifies rsp_valid; POLL exhausted
- ena, wea  out  1  port enable / write enable
- addra  out  ADDR_W  port address
- dina  out  DATA_W  port write data
- douta  in  DATA_W  port read data, valid the cycle after a read cycle
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, WR, RD_ISS, RD_CAP, POLL_ISS, POLL_CAP, WAIT, RSP.
- IDLE: cmd_ready=1. On accept, latch op/addr/data/mask and go to the state for the op.
- WR: ena=1, wea=1, addra/dina from the latched command for exactly one cycle, then IDLE. No response.
- RD_ISS: ena=1, wea=0 for one cycle. RD_CAP: ena=0; latch douta into rsp_data. RSP: rsp_valid=1, then IDLE.
- POLL: the POLL_ISS/POLL_CAP pair repeats.
  - In POLL_CAP, match = ((douta ^ data) & mask) == 0.
  - Match: go to RSP with rsp_timeout=0.
  - No match: increment the 16-bit poll count. If count+1 == POLL_MAX, go to RSP with rsp_timeout=1 and rsp_data = last douta. Otherwise return to POLL_ISS.
  - mask=0 always matches on the first read.
- WAIT: count down cmd_data[15:0] idle cycles (ena=0), then IDLE. A count of 0 returns to IDLE after one cycle. No response.
- ena, wea, addra and dina are registered. addra and dina hold their last values when ena=0.
- The driver does not interpret the address map. The sequence is fully defined by the command list.

## Timing
- Let T be the accept cycle.
  - WRITE: ena high in T+1; next accept possible in T+2.
  - READ: ena high in T+1, douta captured at the end of T+2, rsp_valid in T+3; next accept in T+4.
  - POLL: each iteration takes 2 cycles. A match on the k-th read gives rsp_valid in T+2k+1.
  - WAIT n: next accept in T+n+2 (n=0 → T+2).
- Reset values: ena=0, wea=0, addra=0, dina=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, busy=0, state=IDLE, so cmd_ready=1 once reset deasserts.
- Reset mid-command: the command is aborted and ena drops immediately (asynchronous reset). No response is issued.
- rsp_timeout is 0 whenever rsp_valid is 0.
- cmd inputs are ignored outside IDLE.

## Structure
- npu_host_pkg holds:
  - the op enum;
  - the address map: SEL_IMG=1, SEL_WCONV=2, SEL_FC1W=3, SEL_FC2W=4, SEL_CTRL=5, SEL_STAT=7, with sel at addr[14:12] and idx at addr[11:0];
  - status offsets: DONE=0, RESULT=4, PIX_VALID=8, PIX=12, FC1_VALID=16, FCN_DONE=20;
  - CTRL bits: TRIGGER=0, SAVE_DONE=2, NEXT_LAYER=3, START=4, FC1_NEXT=5.
- Single module; the poll counter and WAIT counter share one 16-bit down/up counter inline. No sub-module.

## Test plan
- WRITE addr 0x1000 data 0xDDCCBBAA → exactly one cycle with ena=1, wea=1, addra=0x1000, dina=0xDDCCBBAA at T+1; cmd_ready back high at T+2.
- READ 0x7004 with the responder model returning 0xFFFFFF85 → rsp_valid at T+3, rsp_data=0xFFFFFF85, rsp_timeout=0.
- POLL 0x7000, mask=1, data=1, with the model returning 0 for 5 reads then 1 → 6 read cycles, rsp_valid at T+13, rsp_data=1.
- POLL with POLL_MAX=4 and the model never matching → exactly 4 reads, rsp_valid with rsp_timeout=1.
- WAIT 3 followed by WRITE → no ena for 3 cycles; the WRITE is accepted at T+5.
- rst asserted during POLL_ISS → ena=0 the same cycle, no rsp_valid; after release a READ completes normally.

Source files
------------

// File: rtl/npu_host_pkg.sv
// Shared definitions for the NPU host driver: command opcodes and the
// NPU register/memory window address map used by command scripts.
package npu_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_POLL  = 2'd2,
    OP_WAIT  = 2'd3
  } op_e;

  // Address map: sel in addr[14:12], idx in addr[11:0]
  localparam int SEL_LSB = 12;
  localparam int IDX_W   = 12;

  localparam logic [2:0] SEL_IMG   = 3'd1;
  localparam logic [2:0] SEL_WCONV = 3'd2;
  localparam logic [2:0] SEL_FC1W  = 3'd3;
  localparam logic [2:0] SEL_FC2W  = 3'd4;
  localparam logic [2:0] SEL_CTRL  = 3'd5;
  localparam logic [2:0] SEL_STAT  = 3'd7;

  // Status window offsets
  localparam logic [11:0] STAT_DONE      = 12'd0;
  localparam logic [11:0] STAT_RESULT    = 12'd4;
  localparam logic [11:0] STAT_PIX_VALID = 12'd8;
  localparam logic [11:0] STAT_PIX       = 12'd12;
  localparam logic [11:0] STAT_FC1_VALID = 12'd16;
  localparam logic [11:0] STAT_FCN_DONE  = 12'd20;

  // Control register bit positions
  localparam int CTRL_TRIGGER    = 0;
  localparam int CTRL_SAVE_DONE  = 2;
  localparam int CTRL_NEXT_LAYER = 3;
  localparam int CTRL_START      = 4;
  localparam int CTRL_FC1_NEXT   = 5;

  // Build a 16-bit window address from a select and an index
  function automatic logic [15:0] mk_addr(input logic [2:0] sel, input logic [11:0] idx);
    return {1'b0, sel, idx};
  endfunction

endpackage

// File: rtl/npu_host_driver.sv
// Command-stream initiator for the NPU single-port window. Turns
// WRITE/READ/POLL/WAIT commands into registered port cycles and returns
// read data as a one-cycle response pulse.
//
// state    | meaning
// IDLE     | ready for a command
// WR       | write cycle on the port
// RD_ISS   | read cycle on the port
// RD_CAP   | douta valid, captured into response register
// POLL_ISS | poll read cycle on the port
// POLL_CAP | compare douta against expected value under mask
// WAIT     | idle cycles counting down
// RSP      | response pulse
module npu_host_driver
  import npu_host_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int unsigned POLL_MAX = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISS, S_RD_CAP, S_POLL_ISS, S_POLL_CAP, S_WAIT, S_RSP
  } state_e;

  localparam logic [16:0] POLL_LIM = 17'(POLL_MAX);

  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_mask;
  logic [15:0]       r_cnt;
  logic              r_ena, r_wea, r_timeout;
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina, r_rsp_data;
  logic              w_accept, w_match, w_poll_last, w_issue;

  assign w_accept    = cmd_valid && (r_state == S_IDLE);
  assign w_match     = ((douta ^ r_data) & r_mask) == '0;
  assign w_poll_last = ({1'b0, r_cnt} + 17'd1) == POLL_LIM;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode; port cycles are issued based on the state being entered
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          unique case (op_e'(cmd_op))
            OP_WRITE: w_next = S_WR;
            OP_READ:  w_next = S_RD_ISS;
            OP_POLL:  w_next = S_POLL_ISS;
            OP_WAIT:  w_next = S_WAIT;
          endcase
        end
      end
      S_WR:       w_next = S_IDLE;
      S_RD_ISS:   w_next = S_RD_CAP;
      S_RD_CAP:   w_next = S_RSP;
      S_POLL_ISS: w_next = S_POLL_CAP;
      S_POLL_CAP: begin
        if (w_match || w_poll_last) w_next = S_RSP;
        else                        w_next = S_POLL_ISS;
      end
      S_WAIT:     if (r_cnt == 16'd0) w_next = S_IDLE;
      S_RSP:      w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    w_issue = (w_next == S_WR) || (w_next == S_RD_ISS) || (w_next == S_POLL_ISS);
  end

  // Latch the accepted command; one counter serves both poll count and wait count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
      r_mask <= '0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_addr <= cmd_addr;
      r_data <= cmd_data;
      r_mask <= cmd_mask;
      r_cnt  <= (op_e'(cmd_op) == OP_WAIT) ? cmd_data[15:0] : 16'd0;
    end else if (r_state == S_WAIT && r_cnt != 16'd0) begin
      r_cnt <= r_cnt - 16'd1;
    end else if (r_state == S_POLL_CAP && !w_match) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Registered port drive; address and data hold while the port is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ena   <= 1'b0;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
    end else begin
      r_ena <= w_issue;
      r_wea <= (w_next == S_WR);
      if (w_issue) r_addra <= w_accept ? cmd_addr : r_addr;
      if (w_next == S_WR) r_dina <= cmd_data;
    end
  end

  // Capture read data and timeout status one cycle after each read cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == S_RD_CAP) begin
      r_rsp_data <= douta;
      r_timeout  <= 1'b0;
    end else if (r_state == S_POLL_CAP) begin
      r_rsp_data <= douta;
      r_timeout  <= !w_match;
    end
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign rsp_valid   = (r_state == S_RSP);
  assign rsp_timeout = (r_state == S_RSP) && r_timeout;
  assign rsp_data    = r_rsp_data;
  assign ena         = r_ena;
  assign wea         = r_wea;
  assign addra       = r_addra;
  assign dina        = r_dina;

endmodule
